// File: rtl/regfile_ctrl_pkg.sv
// Shared defaults, FSM state type and constants for the register-file write-port arbiter.
package regfile_ctrl_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_REG_AW = 4;

  // Register 0 is hard-wired; writes to it are dropped.
  localparam int unsigned REG0 = 0;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of writeback, memory-return, scoreboard and register-file write signals.
// master = pipeline/cache/register-file side, slave = the arbiter.
interface regfile_wb_arbiter_if
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int REG_AW = DEFAULT_REG_AW
);

  logic              wb_valid;
  logic [REG_AW-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [REG_AW-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;

  logic              ld_issue_valid;
  logic [REG_AW-1:0] ld_issue_reg;
  logic [REG_AW-1:0] rd_reg1;
  logic [REG_AW-1:0] rd_reg2;
  logic              hazard1;
  logic              hazard2;

  logic              pipe_stall;

  logic              WriteReg;
  logic [REG_AW-1:0] DstReg;
  logic [DATA_W-1:0] DstData;

  modport master (
    output wb_valid, wb_reg, wb_data,
    output mem_valid, mem_reg, mem_data,
    output ld_issue_valid, ld_issue_reg, rd_reg1, rd_reg2,
    input  mem_ready, hazard1, hazard2, pipe_stall,
    input  WriteReg, DstReg, DstData
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data,
    input  mem_valid, mem_reg, mem_data,
    input  ld_issue_valid, ld_issue_reg, rd_reg1, rd_reg2,
    output mem_ready, hazard1, hazard2, pipe_stall,
    output WriteReg, DstReg, DstData
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous-reset circular buffer holding late load returns {reg, data}.
// DEPTH must be a power of two so the pointers wrap without extra logic.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             last_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (pop_i && !push_i) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count gating makes stale entries unobservable.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign last_o  = (count_q == CNT_W'(1));
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and buffered load returns,
// with starvation-forced drain. Optional per-register load scoreboard: define WB_SCOREBOARD_EN.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int REG_AW       = DEFAULT_REG_AW,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int ENTRY_W  = REG_AW + DATA_W;
  localparam int STARVE_W = 4;

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                write_q, write_d;
  logic [REG_AW-1:0]   dst_reg_q, dst_reg_d;
  logic [DATA_W-1:0]   dst_data_q, dst_data_d;

  logic               fifo_push, fifo_full, fifo_empty, fifo_last;
  logic [ENTRY_W-1:0] fifo_head;
  logic [REG_AW-1:0]  head_reg;
  logic [DATA_W-1:0]  head_data;
  logic               grant_wb, grant_fifo;

  assign fifo_push = bus.mem_valid && !fifo_full;
  assign {head_reg, head_data} = fifo_head;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i ({bus.mem_reg, bus.mem_data}),
    .pop_i       (grant_fifo),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .last_o      (fifo_last),
    .head_o      (fifo_head)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant_wb   = 1'b0;
    grant_fifo = 1'b0;
    state_d    = state_q;
    starve_d   = starve_q;
    unique case (state_q)
      NORMAL: begin
        grant_wb   = bus.wb_valid;
        grant_fifo = !bus.wb_valid && !fifo_empty;
        if (fifo_empty || grant_fifo) begin
          starve_d = '0;
        end else begin
          starve_d = starve_q + 1'b1;
          if (starve_d >= STARVE_W'(STARVE_LIMIT)) begin
            state_d = FORCE;
          end
        end
      end
      FORCE: begin
        grant_fifo = !fifo_empty;
        starve_d   = '0;
        // Leave once the final entry pops with nothing arriving behind it.
        if (fifo_empty || (fifo_last && !fifo_push)) begin
          state_d = NORMAL;
        end
      end
      default: ;
    endcase

    write_d    = 1'b0;
    dst_reg_d  = dst_reg_q;
    dst_data_d = dst_data_q;
    if (grant_wb) begin
      write_d    = (bus.wb_reg != REG_AW'(REG0));
      dst_reg_d  = bus.wb_reg;
      dst_data_d = bus.wb_data;
    end else if (grant_fifo) begin
      write_d    = (head_reg != REG_AW'(REG0));
      dst_reg_d  = head_reg;
      dst_data_d = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NORMAL;
      starve_q   <= '0;
      write_q    <= 1'b0;
      dst_reg_q  <= '0;
      dst_data_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      write_q    <= write_d;
      dst_reg_q  <= dst_reg_d;
      dst_data_q <= dst_data_d;
    end
  end

  assign bus.mem_ready  = !fifo_full;
  assign bus.pipe_stall = (state_q == FORCE);
  assign bus.WriteReg   = write_q;
  assign bus.DstReg     = dst_reg_q;
  assign bus.DstData    = dst_data_q;

`ifdef WB_SCOREBOARD_EN
  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0] pending_q, pending_d;

  // A new issue is applied after the clear so it wins on the same register.
  always_comb begin
    pending_d = pending_q;
    if (grant_fifo) begin
      pending_d[head_reg] = 1'b0;
    end
    if (bus.ld_issue_valid && (bus.ld_issue_reg != REG_AW'(REG0))) begin
      pending_d[bus.ld_issue_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign bus.hazard1 = pending_q[bus.rd_reg1];
  assign bus.hazard2 = pending_q[bus.rd_reg2];
`else
  logic unused_sb;
  assign unused_sb   = ^{bus.ld_issue_valid, bus.ld_issue_reg, bus.rd_reg1, bus.rd_reg2};
  assign bus.hazard1 = 1'b0;
  assign bus.hazard2 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_regfile_wb_arbiter;
  import regfile_ctrl_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

  regfile_wb_arbiter #(
    .DATA_W       (DW),
    .REG_AW       (AW),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: arbitration rules applied to a queue, evaluated once per rising edge.
  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ret_t;

  ret_t          m_q[$];
  bit            m_force;
  int            m_starve;
  bit [15:0]     m_pend;
  bit            exp_we;
  logic [AW-1:0] exp_reg;
  logic [DW-1:0] exp_data;

  always @(posedge clk) begin : model
    int   pre_size;
    bit   take_wb, take_mem;
    ret_t e;
    if (rst) begin
      m_q.delete();
      m_force  = 1'b0;
      m_starve = 0;
      m_pend   = '0;
      exp_we   = 1'b0;
      exp_reg  = '0;
      exp_data = '0;
    end else begin
      pre_size = m_q.size();
      take_wb  = !m_force && bus.wb_valid;
      take_mem = !take_wb && (pre_size > 0);
      exp_we   = 1'b0;
      if (take_wb) begin
        exp_we   = (bus.wb_reg != 0);
        exp_reg  = bus.wb_reg;
        exp_data = bus.wb_data;
      end else if (take_mem) begin
        e        = m_q.pop_front();
        exp_we   = (e.r != 0);
        exp_reg  = e.r;
        exp_data = e.d;
        m_pend[e.r] = 1'b0;
      end
      if (bus.ld_issue_valid && bus.ld_issue_reg != 0) m_pend[bus.ld_issue_reg] = 1'b1;
      if (bus.mem_valid && pre_size < DEPTH) m_q.push_back({bus.mem_reg, bus.mem_data});
      if (m_force) begin
        m_starve = 0;
        if (m_q.size() == 0) m_force = 1'b0;
      end else if (pre_size == 0 || take_mem) begin
        m_starve = 0;
      end else begin
        m_starve++;
        if (m_starve >= LIMIT) m_force = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.wb_valid       = 1'b0;
    bus.wb_reg         = '0;
    bus.wb_data        = '0;
    bus.mem_valid      = 1'b0;
    bus.mem_reg        = '0;
    bus.mem_data       = '0;
    bus.ld_issue_valid = 1'b0;
    bus.ld_issue_reg   = '0;
    bus.rd_reg1        = '0;
    bus.rd_reg2        = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.WriteReg !== 1'b0 || bus.DstReg !== 4'd0 || bus.DstData !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b reg=%0d data=%h, want we=0 reg=0 data=0000",
               bus.WriteReg, bus.DstReg, bus.DstData);
    end
    checks++;
    if (bus.pipe_stall !== 1'b0 || bus.mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: got stall=%b ready=%b, want stall=0 ready=1",
               bus.pipe_stall, bus.mem_ready);
    end
    checks++;
    if (bus.hazard1 !== 1'b0 || bus.hazard2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hazard: got h1=%b h2=%b, want 0 0", bus.hazard1, bus.hazard2);
    end
    rst = 1'b0;
  endtask

  task automatic test_pipeline();
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 4'd3;
    bus.wb_data  = 16'h1234;
    tick();
    bus.wb_valid = 1'b0;
    checks++;
    if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'd3 || bus.DstData !== 16'h1234) begin
      errors++;
      $display("FAIL pipe_write: got we=%b reg=%0d data=%h, want we=1 reg=3 data=1234",
               bus.WriteReg, bus.DstReg, bus.DstData);
    end
    checks++;
    if (bus.mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL pipe_ready: got %b want 1", bus.mem_ready);
    end
    tick();
  endtask

  task automatic test_idle_drain();
    bus.mem_valid = 1'b1;
    bus.mem_reg   = 4'd5;
    bus.mem_data  = 16'hBEEF;
    tick();
    bus.mem_valid = 1'b0;
    tick();
    checks++;
    if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'd5 || bus.DstData !== 16'hBEEF) begin
      errors++;
      $display("FAIL idle_drain: got we=%b reg=%0d data=%h, want we=1 reg=5 data=beef",
               bus.WriteReg, bus.DstReg, bus.DstData);
    end
    tick();
    checks++;
    if (bus.WriteReg !== 1'b0 || bus.mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_empty: got we=%b ready=%b, want we=0 ready=1", bus.WriteReg, bus.mem_ready);
    end
  endtask

  task automatic test_starvation();
    bus.mem_valid = 1'b1;
    bus.mem_reg   = 4'd7;
    bus.mem_data  = 16'h00AA;
    bus.wb_valid  = 1'b1;
    bus.wb_reg    = 4'd1;
    bus.wb_data   = 16'h1111;
    tick();
    bus.mem_valid = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      checks++;
      if (bus.pipe_stall !== 1'b0) begin
        errors++;
        $display("FAIL starve_early_stall[%0d]: got %b want 0", i, bus.pipe_stall);
      end
      tick();
      checks++;
      if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'd1) begin
        errors++;
        $display("FAIL starve_wb[%0d]: got we=%b reg=%0d, want we=1 reg=1", i, bus.WriteReg, bus.DstReg);
      end
    end
    checks++;
    if (bus.pipe_stall !== 1'b1) begin
      errors++;
      $display("FAIL starve_stall: got %b want 1", bus.pipe_stall);
    end
    tick();
    checks++;
    if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'd7 || bus.DstData !== 16'h00AA) begin
      errors++;
      $display("FAIL starve_drain: got we=%b reg=%0d data=%h, want we=1 reg=7 data=00aa",
               bus.WriteReg, bus.DstReg, bus.DstData);
    end
    checks++;
    if (bus.pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL starve_stall_len: got %b want 0", bus.pipe_stall);
    end
    tick();
    checks++;
    if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'd1 || bus.DstData !== 16'h1111) begin
      errors++;
      $display("FAIL starve_held_wb: got we=%b reg=%0d data=%h, want we=1 reg=1 data=1111",
               bus.WriteReg, bus.DstReg, bus.DstData);
    end
    bus.wb_valid = 1'b0;
    tick();
  endtask

  task automatic test_full_fifo();
    bus.wb_valid  = 1'b1;
    bus.wb_reg    = 4'd2;
    bus.wb_data   = 16'h2222;
    bus.mem_valid = 1'b1;
    bus.mem_reg   = 4'd10;
    bus.mem_data  = 16'h0A0A;
    tick();
    bus.mem_reg  = 4'd11;
    bus.mem_data = 16'h0B0B;
    tick();
    checks++;
    if (bus.mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b want 0", bus.mem_ready);
    end
    bus.mem_reg  = 4'd12;
    bus.mem_data = 16'h0C0C;
    tick();
    checks++;
    if (bus.mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: got %b want 0", bus.mem_ready);
    end
    bus.wb_valid = 1'b0;
    tick();
    checks++;
    if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'd10 || bus.DstData !== 16'h0A0A || bus.mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop1: got we=%b reg=%0d data=%h ready=%b, want 1 10 0a0a 1",
               bus.WriteReg, bus.DstReg, bus.DstData, bus.mem_ready);
    end
    tick();
    bus.mem_valid = 1'b0;
    checks++;
    if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'd11 || bus.DstData !== 16'h0B0B) begin
      errors++;
      $display("FAIL full_pop2: got we=%b reg=%0d data=%h, want 1 11 0b0b",
               bus.WriteReg, bus.DstReg, bus.DstData);
    end
    tick();
    checks++;
    if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'd12 || bus.DstData !== 16'h0C0C) begin
      errors++;
      $display("FAIL full_third: got we=%b reg=%0d data=%h, want 1 12 0c0c",
               bus.WriteReg, bus.DstReg, bus.DstData);
    end
    tick();
  endtask

  task automatic test_reg0();
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 4'd0;
    bus.wb_data  = 16'hFFFF;
    tick();
    bus.wb_valid = 1'b0;
    checks++;
    if (bus.WriteReg !== 1'b0) begin
      errors++;
      $display("FAIL reg0_wb: got we=%b want 0", bus.WriteReg);
    end
    bus.mem_valid = 1'b1;
    bus.mem_reg   = 4'd0;
    bus.mem_data  = 16'hDEAD;
    tick();
    bus.mem_valid = 1'b0;
    tick();
    checks++;
    if (bus.WriteReg !== 1'b0) begin
      errors++;
      $display("FAIL reg0_mem: got we=%b want 0", bus.WriteReg);
    end
    bus.mem_valid = 1'b1;
    bus.mem_reg   = 4'd6;
    bus.mem_data  = 16'h0606;
    tick();
    bus.mem_valid = 1'b0;
    tick();
    checks++;
    if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'd6 || bus.DstData !== 16'h0606) begin
      errors++;
      $display("FAIL reg0_popped: got we=%b reg=%0d data=%h, want 1 6 0606",
               bus.WriteReg, bus.DstReg, bus.DstData);
    end
    tick();
  endtask

  task automatic test_scoreboard();
`ifdef WB_SCOREBOARD_EN
    bus.ld_issue_valid = 1'b1;
    bus.ld_issue_reg   = 4'd9;
    tick();
    bus.ld_issue_valid = 1'b0;
    bus.rd_reg1 = 4'd9;
    bus.rd_reg2 = 4'd9;
    #1;
    checks++;
    if (bus.hazard1 !== 1'b1 || bus.hazard2 !== 1'b1) begin
      errors++;
      $display("FAIL sb_set: got h1=%b h2=%b want 1 1", bus.hazard1, bus.hazard2);
    end
    bus.mem_valid = 1'b1;
    bus.mem_reg   = 4'd9;
    bus.mem_data  = 16'h9999;
    tick();
    bus.mem_valid = 1'b0;
    tick();
    checks++;
    if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'd9 || bus.hazard1 !== 1'b0) begin
      errors++;
      $display("FAIL sb_clear: got we=%b reg=%0d h1=%b, want 1 9 0", bus.WriteReg, bus.DstReg, bus.hazard1);
    end
    bus.ld_issue_valid = 1'b1;
    tick();
    bus.ld_issue_valid = 1'b0;
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid      = 1'b0;
    bus.ld_issue_valid = 1'b1;
    tick();
    bus.ld_issue_valid = 1'b0;
    checks++;
    if (bus.hazard1 !== 1'b1) begin
      errors++;
      $display("FAIL sb_set_wins: got h1=%b want 1", bus.hazard1);
    end
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b0;
    tick();
    checks++;
    if (bus.hazard1 !== 1'b0) begin
      errors++;
      $display("FAIL sb_final_clear: got h1=%b want 0", bus.hazard1);
    end
`else
    bus.ld_issue_valid = 1'b1;
    bus.ld_issue_reg   = 4'd9;
    tick();
    bus.ld_issue_valid = 1'b0;
    bus.rd_reg1 = 4'd9;
    bus.rd_reg2 = 4'd9;
    #1;
    checks++;
    if (bus.hazard1 !== 1'b0 || bus.hazard2 !== 1'b0) begin
      errors++;
      $display("FAIL sb_disabled: got h1=%b h2=%b want 0 0", bus.hazard1, bus.hazard2);
    end
`endif
    bus.rd_reg1 = '0;
    bus.rd_reg2 = '0;
    tick();
  endtask

  task automatic test_reset_in_force();
    bus.wb_valid       = 1'b1;
    bus.wb_reg         = 4'd1;
    bus.wb_data        = 16'h5555;
    bus.mem_valid      = 1'b1;
    bus.mem_reg        = 4'd13;
    bus.mem_data       = 16'h0D0D;
    bus.ld_issue_valid = 1'b1;
    bus.ld_issue_reg   = 4'd13;
    tick();
    bus.ld_issue_valid = 1'b0;
    bus.mem_reg        = 4'd14;
    bus.mem_data       = 16'h0E0E;
    tick();
    bus.mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.pipe_stall !== 1'b1) begin
      errors++;
      $display("FAIL rstf_enter: got stall=%b want 1", bus.pipe_stall);
    end
    rst = 1'b1;
    bus.rd_reg1 = 4'd13;
    tick();
    checks++;
    if (bus.pipe_stall !== 1'b0 || bus.mem_ready !== 1'b1 || bus.WriteReg !== 1'b0 || bus.hazard1 !== 1'b0) begin
      errors++;
      $display("FAIL rstf_state: got stall=%b ready=%b we=%b h1=%b, want 0 1 0 0",
               bus.pipe_stall, bus.mem_ready, bus.WriteReg, bus.hazard1);
    end
    rst = 1'b0;
    clear_inputs();
    tick();
    checks++;
    if (bus.WriteReg !== 1'b0) begin
      errors++;
      $display("FAIL rstf_discard: got we=%b want 0", bus.WriteReg);
    end
  endtask

  task automatic test_random(input int n);
    bit eh1, eh2;
    int fails_shown = 0;
    for (int i = 0; i < n; i++) begin
      bus.wb_valid       = ($urandom_range(0, 9) < 7);
      bus.wb_reg         = AW'($urandom_range(0, 15));
      bus.wb_data        = DW'($urandom);
      bus.mem_valid      = ($urandom_range(0, 9) < 5);
      bus.mem_reg        = AW'($urandom_range(0, 15));
      bus.mem_data       = DW'($urandom);
      bus.ld_issue_valid = ($urandom_range(0, 9) < 3);
      bus.ld_issue_reg   = AW'($urandom_range(0, 15));
      bus.rd_reg1        = AW'($urandom_range(0, 15));
      bus.rd_reg2        = AW'($urandom_range(0, 15));
      #1;
`ifdef WB_SCOREBOARD_EN
      eh1 = m_pend[bus.rd_reg1];
      eh2 = m_pend[bus.rd_reg2];
`else
      eh1 = 1'b0;
      eh2 = 1'b0;
`endif
      checks++;
      if (bus.mem_ready !== (m_q.size() < DEPTH) || bus.pipe_stall !== m_force ||
          bus.hazard1 !== eh1 || bus.hazard2 !== eh2) begin
        errors++;
        if (fails_shown++ < 20)
          $display("FAIL rand_flags[%0d]: got ready=%b stall=%b h1=%b h2=%b, want %b %b %b %b", i,
                   bus.mem_ready, bus.pipe_stall, bus.hazard1, bus.hazard2,
                   (m_q.size() < DEPTH), m_force, eh1, eh2);
      end
      tick();
      checks++;
      if (bus.WriteReg !== exp_we || (exp_we && (bus.DstReg !== exp_reg || bus.DstData !== exp_data))) begin
        errors++;
        if (fails_shown++ < 20)
          $display("FAIL rand_write[%0d]: got we=%b reg=%0d data=%h, want we=%b reg=%0d data=%h", i,
                   bus.WriteReg, bus.DstReg, bus.DstData, exp_we, exp_reg, exp_data);
      end
    end
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pipeline();
    test_idle_drain();
    test_starvation();
    test_full_fifo();
    test_reg0();
    test_scoreboard();
    test_reset_in_force();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    test_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
